// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file write port between ALU and
// load writeback, plus a per-register pending-write scoreboard for decode stalls.
module regfile_write_arbiter #(
  parameter int NREG = 64,
  parameter int AW   = 6,
  parameter int DW   = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [AW-1:0]   alu_rd,
  input  logic [DW-1:0]   alu_data,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic [AW-1:0]   mem_rd,
  input  logic [DW-1:0]   mem_data,
  input  logic            dec_valid,
  input  logic            dec_wr,
  input  logic [AW-1:0]   dec_rd,
  input  logic [AW-1:0]   rs,
  input  logic [AW-1:0]   rt,
  output logic            stall,
  input  logic            flush,
  output logic            wrt,
  output logic [AW-1:0]   rd,
  output logic [DW-1:0]   datain,
  output logic [NREG-1:0] busy
);

  typedef enum logic {SRC_ALU = 1'b0, SRC_MEM = 1'b1} src_e;

  src_e            rr_last_q, rr_last_d;
  logic            wrt_q, wrt_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [DW-1:0]   datain_q, datain_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic            alu_xfer, mem_xfer, issue;

  // The requester that did not win last gets priority on a tie.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    alu_ready = 1'b0;
    mem_ready = 1'b0;
    if (!flush) begin
      if (alu_valid && (!mem_valid || rr_last_q == SRC_MEM)) alu_ready = 1'b1;
      else if (mem_valid)                                    mem_ready = 1'b1;
    end
  end

  assign alu_xfer = alu_valid & alu_ready;
  assign mem_xfer = mem_valid & mem_ready;

  assign stall = dec_valid & (busy_q[rs] | busy_q[rt] | (dec_wr & busy_q[dec_rd]));
  assign issue = dec_valid & dec_wr & ~stall;

  always_comb begin
    wrt_d     = 1'b0;
    rd_d      = rd_q;
    datain_d  = datain_q;
    rr_last_d = rr_last_q;
    if (alu_xfer) begin
      wrt_d     = 1'b1;
      rd_d      = alu_rd;
      datain_d  = alu_data;
      rr_last_d = SRC_ALU;
    end else if (mem_xfer) begin
      wrt_d     = 1'b1;
      rd_d      = mem_rd;
      datain_d  = mem_data;
      rr_last_d = SRC_MEM;
    end
  end

  // Clear before set so a same-cycle re-issue keeps the newer write pending.
  always_comb begin
    busy_d = busy_q;
    if (alu_xfer) busy_d[alu_rd] = 1'b0;
    if (mem_xfer) busy_d[mem_rd] = 1'b0;
    if (issue)    busy_d[dec_rd] = 1'b1;
    if (flush)    busy_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrt_q     <= 1'b0;
      rd_q      <= '0;
      datain_q  <= '0;
      busy_q    <= '0;
      rr_last_q <= SRC_MEM;
    end else begin
      // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
      wrt_q     <= wrt_d;
      rd_q      <= rd_d;
      datain_q  <= datain_d;
      busy_q    <= busy_d;
      rr_last_q <= rr_last_d;
    end
  end

  assign wrt    = wrt_q;
  assign rd     = rd_q;
  assign datain = datain_q;
  assign busy   = busy_q;

endmodule
